float32_to_offset14_conv: RTL and testbench

//   Converts an IEEE-754 single-precision float to a 14-bit offset-binary code.
//   The float is a signed sample in units of 1 LSB, nominal range -8192..+8191.

---
 rtl/float32_to_offset14_conv_if.sv | 11 +
 rtl/float32_to_offset14_conv.sv | 120 ++++++++++++
 tb/tb_float32_to_offset14_conv.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/float32_to_offset14_conv_if.sv
// Sample bus for the float32 -> offset-binary converter.
//   float_in : IEEE-754 binary32 sample, driven by the producer (master)
//   out_data : 14-bit offset-binary code, driven by the converter (slave)
// There is no handshake: the converter samples float_in on every rising edge.
interface float32_to_offset14_conv_if;
  logic [31:0] float_in;
  logic [13:0] out_data;

  modport master (output float_in, input  out_data);
  modport slave  (input  float_in, output out_data);
endinterface

// File: rtl/float32_to_offset14_conv.sv
// float32_to_offset14_conv
//   Converts a binary32 sample (units of 1 LSB, nominal -8192..+8191) to a
//   14-bit offset-binary DAC code: round half away from zero, clamp to
//   [-8192, +8191], add 8192. Zero, subnormals and NaN give mid-scale (8192);
//   infinities and |x| >= 8192 saturate toward their sign.
//   Two-stage pipeline, one sample per clock, latency 2 rising edges.
// Ports
//   aclk     in  rising-edge clock
//   aresetn  in  asynchronous active-low reset; forces out_data to 8192
//   bus      slave modport: float_in (in, 32), out_data (out, 14)
module float32_to_offset14_conv (
  input logic                        aclk,
  input logic                        aresetn,
  float32_to_offset14_conv_if.slave  bus
);

  // Result class decided in stage 1; stage 2 only needs these three cases.
  typedef enum logic [1:0] {
    CLS_MID = 2'd0,  // zero, subnormal, NaN, |x| < 0.5
    CLS_NUM = 2'd1,  // finite, 0.5 <= |x| < 8192: needs rounding/clamping
    CLS_SAT = 2'd2   // |x| >= 8192 or infinity: full scale toward the sign
  } cls_t;

  localparam logic [13:0] MID_SCALE = 14'h2000;
  localparam logic [13:0] FULL_POS  = 14'h3FFF;
  localparam logic [13:0] FULL_NEG  = 14'h0000;

  // ---------------------------------------------------------------------------
  // Stage 1: decode and align
  // ---------------------------------------------------------------------------
  logic        sign_in;
  logic [7:0]  exp_in;
  logic [22:0] frac_in;

  assign sign_in = bus.float_in[31];
  assign exp_in  = bus.float_in[30:23];
  assign frac_in = bus.float_in[22:0];

  cls_t        cls_d;
  logic [4:0]  shift_d;
  logic [13:0] half_d;

  // half_d is the magnitude in half-LSB units, truncated: the integer part in
  // [13:1] and the round bit (the 0.5 weight) in [0]. With ties going away
  // from zero, round-up depends only on that bit, so the bits below it are
  // not carried. For biased exponents 126..139 (e = -1..12) the right shift
  // of the 24-bit mantissa is 149 - exp, i.e. 10..23.
  always_comb begin
    // NOTE: every output of this block gets a default first so that no path
    // leaves one unassigned and infers a latch.
    cls_d   = CLS_MID;
    shift_d = '0;
    half_d  = '0;
    if (exp_in == 8'd255) begin
      cls_d = (frac_in == '0) ? CLS_SAT : CLS_MID;
    end else if (exp_in >= 8'd140) begin
      cls_d = CLS_SAT;
    end else if (exp_in >= 8'd126) begin
      cls_d   = CLS_NUM;
      shift_d = 5'(8'd149 - exp_in);
      half_d  = 14'({1'b1, frac_in} >> shift_d);
    end
  end

  logic        s1_sign;
  cls_t        s1_cls;
  logic [13:0] s1_half;

  // NOTE: sequential state is written with non-blocking assignments so every
  // register samples the pre-edge value of its inputs.
  // NOTE: all pipeline registers reset; a cleared stage 1 (CLS_MID) makes the
  // first output after release mid-scale, never stale data.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      s1_sign <= 1'b0;
      s1_cls  <= CLS_MID;
      s1_half <= '0;
    end else begin
      s1_sign <= sign_in;
      s1_cls  <= cls_d;
      s1_half <= half_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: round, apply sign, clamp, offset
  // ---------------------------------------------------------------------------
  logic [13:0] mag;
  logic [13:0] out_d;

  // Largest rounded magnitude is 8192 (from 8191.5), which still fits 14 bits.
  assign mag = {1'b0, s1_half[13:1]} + 14'(s1_half[0]);

  always_comb begin
    out_d = MID_SCALE;
    unique case (s1_cls)
      CLS_SAT: out_d = s1_sign ? FULL_NEG : FULL_POS;
      CLS_NUM: begin
        if (s1_sign) begin
          // mag <= 8192, so -mag is always inside the negative limit.
          out_d = MID_SCALE - mag;
        end else if (mag[13]) begin
          out_d = FULL_POS;
        end else begin
          out_d = MID_SCALE + mag;
        end
      end
      default: out_d = MID_SCALE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      bus.out_data <= MID_SCALE;
    end else begin
      bus.out_data <= out_d;
    end
  end

endmodule

// File: tb/tb_float32_to_offset14_conv.sv
// Self-checking bench for float32_to_offset14_conv.
// The reference model decodes the float into a real number, rounds and
// clamps it arithmetically, and a two-entry history stands in for the
// two-edge latency (mid-scale until two edges have passed since reset).
module tb_float32_to_offset14_conv;

  logic aclk;
  logic aresetn;

  float32_to_offset14_conv_if bus ();

  float32_to_offset14_conv dut (
    .aclk    (aclk),
    .aresetn (aresetn),
    .bus     (bus.slave)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [13:0] act, input logic [13:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: value of the float, rounded half away from zero, clamped, offset.
  function automatic logic [13:0] model(input logic [31:0] f);
    int  ex;
    real mag;
    real r;
    ex = int'(f[30:23]);
    if (ex == 0) return 14'd8192;
    if (ex == 255) begin
      if (f[22:0] != 0) return 14'd8192;
      return f[31] ? 14'd0 : 14'd16383;
    end
    mag = (1.0 + real'(f[22:0]) / 8388608.0) * (2.0 ** real'(ex - 127));
    r = $floor(mag + 0.5);
    if (f[31]) r = -r;
    if (r > 8191.0)  r = 8191.0;
    if (r < -8192.0) r = -8192.0;
    return 14'(int'(r) + 8192);
  endfunction

  // Expected-output history: hist[0] after one edge, hist[1] after two.
  logic [13:0] hist [2];

  always @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      hist[0] = 14'd8192;
      hist[1] = 14'd8192;
    end else begin
      hist[1] = hist[0];
      hist[0] = model(bus.float_in);
    end
  end

  // One compare process: every falling edge, output must match the model.
  always @(negedge aclk) begin
    check("stream", bus.out_data, hist[1]);
  end

  // Directed vectors with hand-computed results.
  typedef struct {
    logic [31:0] f;
    logic [13:0] y;
  } vec_t;

  vec_t dir[19] = '{
    '{32'h45E003EF, 14'd15360}, '{32'h45F0BEE4, 14'd15896},
    '{32'h45FFDEC4, 14'd16380}, '{32'hC5F8B36B, 14'd234},
    '{32'h40200000, 14'd8195},  '{32'hC0200000, 14'd8189},
    '{32'h3F000000, 14'd8193},  '{32'h3EFFFFFF, 14'd8192},
    '{32'h46000000, 14'd16383}, '{32'hC6000000, 14'd0},
    '{32'h7F800000, 14'd16383}, '{32'hFF800000, 14'd0},
    '{32'hC6800000, 14'd0},     '{32'h00000000, 14'd8192},
    '{32'h80000000, 14'd8192},  '{32'h00000001, 14'd8192},
    '{32'h7FC00000, 14'd8192},  '{32'h45FFFC00, 14'd16383},
    '{32'h44D90BDF, 14'd9928}
  };

  function automatic logic [31:0] rand_float();
    logic [31:0] f;
    int sel;
    sel = $urandom_range(0, 9);
    f = $urandom;
    if (sel < 6) begin
      f[30:23] = 8'($urandom_range(120, 142));     // mostly the live range
    end else if (sel == 6) begin
      f[22:0] = (f[0]) ? 23'h400000 : 23'h000000; // exact halves / integers
      f[30:23] = 8'($urandom_range(126, 140));
    end else if (sel == 7) begin
      f[30:23] = f[1] ? 8'd255 : 8'd0;             // specials
    end
    return f;
  endfunction

  initial begin
    aresetn      = 1'b0;
    bus.float_in = 32'h44D90BDF;
    repeat (3) @(posedge aclk);
    #1 check("reset_mid_scale", bus.out_data, 14'd8192);

    // Pin the model against hand-computed values.
    foreach (dir[i]) check($sformatf("model_%08h", dir[i].f), model(dir[i].f), dir[i].y);

    // Reset release and latency: first result two edges later.
    @(negedge aclk);
    aresetn      = 1'b1;
    bus.float_in = 32'h44D90BDF;
    @(posedge aclk);
    #1 check("latency_edge1", bus.out_data, 14'd8192);
    @(posedge aclk);
    #1 check("latency_edge2", bus.out_data, 14'd9928);

    // Directed stream, one per clock.
    foreach (dir[i]) begin
      @(negedge aclk);
      bus.float_in = dir[i].f;
    end

    // Randomized stream.
    for (int n = 0; n < 2000; n++) begin
      @(negedge aclk);
      bus.float_in = rand_float();
    end

    // Async reset mid-stream: no clock edge needed.
    @(negedge aclk);
    bus.float_in = 32'h45E003EF;
    @(posedge aclk);
    #2 aresetn = 1'b0;
    #1 check("async_reset", bus.out_data, 14'd8192);
    @(negedge aclk);
    aresetn      = 1'b1;
    bus.float_in = 32'hC0200000;
    @(posedge aclk);
    #1 check("resume_edge1", bus.out_data, 14'd8192);
    @(negedge aclk);
    bus.float_in = 32'h40200000;
    @(posedge aclk);
    #1 check("resume_edge2", bus.out_data, 14'd8189);
    @(posedge aclk);
    #1 check("resume_edge3", bus.out_data, 14'd8195);

    for (int n = 0; n < 200; n++) begin
      @(negedge aclk);
      bus.float_in = rand_float();
    end
    repeat (3) @(negedge aclk);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no end of run, expected finish");
    $fatal(1);
  end

endmodule
